tile_spawner: RTL and testbench

TILE_SPAWNER -- requirements
Module: tile_spawner

---
 rtl/tile_spawner.sv | 89 ++++++++
 tb/tb_tile_spawner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tile_spawner.sv
// tile_spawner: picks a pseudo-random empty board cell and pulses a one-hot preset with a new tile exponent.
//   clk          : single clock, rising edge
//   rst          : asynchronous, active-low reset
//   start        : spawn request, sampled only in IDLE
//   board_values : 16 cell exponents, 4 bits each, 0 = empty
//   spawn_en     : one-hot preset strobe for the chosen cell
//   spawn_value  : exponent to preset (1 or 2), 0 when no strobe
//   busy         : high while scanning for an empty cell
//   done         : one-cycle completion pulse
//   board_full   : last accepted request found no empty cell
module tile_spawner #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] board_values,
  output logic [15:0] spawn_en,
  output logic [3:0]  spawn_value,
  output logic        busy,
  output logic        done,
  output logic        board_full
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, mask_q, mask_d, spawn_en_q, spawn_en_d, empty;
  logic [3:0]  ptr_q, ptr_d, value_q, value_d;
  logic        busy_q, busy_d, done_q, done_d, full_q, full_d;
  for (genvar i = 0; i < 16; i++) begin : g_empty
    assign empty[i] = ~|board_values[4*i +: 4];
  end
  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d    = state_q;
    ptr_d      = ptr_q;
    mask_d     = mask_q;
    spawn_en_d = '0;
    value_d    = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    full_d     = full_q;
    if (state_q == IDLE) begin
      if (start) begin
        mask_d  = empty;
        ptr_d   = lfsr_q[3:0];
        full_d  = ~|empty;
        done_d  = ~|empty;
        busy_d  = |empty;
        state_d = |empty ? SCAN : IDLE;
      end
    end else if (mask_q[ptr_q]) begin
      spawn_en_d = 16'd1 << ptr_q;
      value_d    = (lfsr_q[7:5] == 3'b000) ? 4'd2 : 4'd1;
      done_d     = 1'b1;
      busy_d     = 1'b0;
      state_d    = IDLE;
    end else begin
      ptr_d = ptr_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      ptr_q      <= '0;
      mask_q     <= '0;
      spawn_en_q <= '0;
      value_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      ptr_q      <= ptr_d;
      mask_q     <= mask_d;
      spawn_en_q <= spawn_en_d;
      value_q    <= value_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      full_q     <= full_d;
    end
  end
  assign spawn_en    = spawn_en_q;
  assign spawn_value = value_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign board_full  = full_q;
endmodule

// File: tb/tb_tile_spawner.sv
// tb_tile_spawner: randomized and directed checks of tile_spawner against an event-level reference model.
module tb_tile_spawner;
  localparam logic [15:0] SEED = 16'hACE1;
  logic        clk = 0, rst = 1, start = 0;
  logic [63:0] board_values = '0;
  logic [15:0] spawn_en;
  logic [3:0]  spawn_value;
  logic        busy, done, board_full;

  tile_spawner #(.SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .board_values(board_values),
    .spawn_en(spawn_en), .spawn_value(spawn_value), .busy(busy),
    .done(done), .board_full(board_full)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_sp = 0, n_two = 0;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // reference: LFSR value seen at the next edge, plus a scheduled spawn
  logic [15:0] m_lfsr, cur, mask, e_en;
  logic [3:0]  e_val, m_tgt;
  logic        e_busy, e_done, e_full;
  int          m_cnt, d;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr = SEED; m_cnt = 0; e_en = 0; e_val = 0; e_busy = 0; e_done = 0; e_full = 0;
    end else begin
      cur = m_lfsr;
      m_lfsr = step(m_lfsr);
      e_en = 0; e_val = 0; e_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          e_en = 16'd1 << m_tgt;
          e_val = (cur[7:5] == 0) ? 4'd2 : 4'd1;
          e_done = 1; e_busy = 0;
        end
      end else if (start) begin
        for (int k = 0; k < 16; k++) mask[k] = (board_values[4*k +: 4] == 0);
        e_full = (mask == 0);
        if (mask == 0) e_done = 1;
        else begin
          d = 0;
          while (!mask[(cur[3:0] + d) % 16]) d++;
          m_tgt = 4'((cur[3:0] + d) % 16);
          m_cnt = d + 1;
          e_busy = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("spawn_en", spawn_en, e_en);
    chk("spawn_value", 16'(spawn_value), 16'(e_val));
    chk("busy", 16'(busy), 16'(e_busy));
    chk("done", 16'(done), 16'(e_done));
    chk("board_full", 16'(board_full), 16'(e_full));
    if (spawn_en != 0) begin
      n_sp++;
      if (spawn_value == 4'd2) n_two++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] only_empty(input int c);
    logic [63:0] b;
    b = {16{4'h1}};
    b[4*c +: 4] = 4'h0;
    return b;
  endfunction

  task automatic wait_gap(input int c, input int lo);
    logic [3:0] g;
    int i;
    g = 4'(c) - m_lfsr[3:0];
    for (i = 0; i < 200 && g < 4'(lo); i++) begin
      tick();
      g = 4'(c) - m_lfsr[3:0];
    end
    chk("gap_wait_bound", 16'(g >= 4'(lo)), 16'd1);
  endtask

  initial begin
    logic [3:0]  p;
    int          n, sp0, two0, thr;
    logic [63:0] b;
    #1 rst = 0;
    repeat (3) tick();
    chk("rst_outputs", {spawn_en[11:0], spawn_value}, 16'h0);
    chk("rst_flags", {13'd0, busy, done, board_full}, 16'h0);

    // first request after reset always sees SEED: ptr0 = 1, value bits of 59C3 -> 1
    board_values = '0; start = 1; rst = 1;
    tick(); start = 0;
    chk("seed_busy", 16'(busy), 16'd1);
    tick();
    chk("seed_en", spawn_en, 16'h0002);
    chk("seed_val", 16'(spawn_value), 16'd1);
    tick();
    chk("pulse_one_cycle", {spawn_en[14:0], done}, 16'h0);

    // full board
    board_values = {16{4'h3}}; start = 1;
    tick(); start = 0;
    chk("full_flags", {13'd0, busy, done, board_full}, 16'h3);
    chk("full_en", spawn_en, 16'h0);
    repeat (3) tick();
    chk("full_hold", {13'd0, busy, done, board_full}, 16'h1);

    // all empty: target is ptr0 itself
    board_values = '0; p = m_lfsr[3:0]; start = 1;
    tick(); start = 0;
    chk("allempty_busy", 16'(busy), 16'd1);
    tick();
    chk("allempty_en", spawn_en, 16'd1 << p);
    chk("allempty_clrfull", {14'd0, busy, board_full}, 16'h0);

    // wrap from ptr0 = 15 to cell 0
    board_values = only_empty(0);
    for (int i = 0; i < 200 && m_lfsr[3:0] != 4'd15; i++) tick();
    chk("ptr15_wait", 16'(m_lfsr[3:0]), 16'd15);
    start = 1; tick(); start = 0;
    tick();
    chk("wrap_e1", spawn_en, 16'h0);
    tick();
    chk("wrap_e2", spawn_en, 16'h0001);

    // only cell 9 empty: latency = 1 + ((9 - ptr0) mod 16)
    board_values = only_empty(9); tick();
    p = m_lfsr[3:0]; start = 1; tick(); start = 0;
    n = 0;
    for (int i = 0; i < 20 && !done; i++) begin tick(); n++; end
    chk("c9_latency", 16'(n), 16'(1 + ((9 - int'(p)) & 15)));
    chk("c9_en", spawn_en, 16'h0200);

    // start chatter and board change mid-scan: one spawn, snapshot target
    board_values = only_empty(3);
    wait_gap(3, 8);
    sp0 = n_sp; start = 1; tick();
    for (int i = 0; i < 5; i++) begin start = ~start; board_values = '0; tick(); end
    start = 0;
    for (int i = 0; i < 20 && !done; i++) tick();
    chk("chatter_en", spawn_en, 16'h0008);
    repeat (4) tick();
    chk("chatter_count", 16'(n_sp - sp0), 16'd1);

    // reset mid-scan
    board_values = only_empty(3);
    wait_gap(3, 8);
    sp0 = n_sp; start = 1; tick(); start = 0; tick();
    chk("midscan_busy", 16'(busy), 16'd1);
    rst = 0; #1;
    chk("async_rst_out", spawn_en | {11'd0, spawn_value, busy}, 16'h0);
    chk("async_rst_flags", {14'd0, done, board_full}, 16'h0);
    repeat (20) tick();
    chk("rst_no_pulse", 16'(n_sp - sp0), 16'd0);

    // reproducible sequence, 1000 back-to-back spawns on an empty board
    board_values = '0; start = 1; rst = 1;
    sp0 = n_sp; two0 = n_two;
    tick(); tick();
    chk("repro_en", spawn_en, 16'h0002);
    for (int i = 0; i < 2200 && n_sp - sp0 < 1000; i++) tick();
    start = 0;
    chk("spawn_1000", 16'(n_sp - sp0), 16'd1000);
    n = n_two - two0;
    chk("ratio_two", 16'(n >= 70 && n <= 190), 16'd1);
    tick(); tick();

    // random traffic
    thr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) thr = ($urandom_range(0, 2) == 0) ? 0 : ($urandom_range(0, 1) ? 1 : 8);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 16; k++)
          b[4*k +: 4] = ($urandom_range(0, 15) < thr) ? 4'h0 : 4'($urandom_range(1, 15));
        board_values = b;
      end
      tick();
    end
    start = 0;
    repeat (20) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
